nvram_restore: RTL and testbench

NVRAM_RESTORE -- requirements
Module: nvram_restore

---
 rtl/nvram_restore.sv | 179 +++++++++++++++++
 tb/tb_nvram_restore.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_restore.sv
// nvram_restore: captures a hiscore/NVRAM dump streamed over the HPS ioctl
// interface into a local buffer, then, after a start delay, halts the CPU and
// replays the buffer into game RAM one byte every two cycles.
//
// Ports:
//   clk, reset_n                       core clock, async active-low reset
//   ioctl_download/index/wr/addr/dout  HPS download stream
//   paused                             core confirms the CPU is halted
//   pause_cpu                          request CPU halt
//   ram_address/ram_data_in/ram_write  game RAM write port
//   busy                               any state other than idle
//   done                               one-cycle pulse after a completed restore
module nvram_restore #(
  parameter int unsigned DUMPWIDTH  = 8,
  parameter int unsigned DUMPINDEX  = 4,
  parameter logic [31:0] STARTDELAY = 32'd1000,
  parameter int unsigned PAUSEPAD   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic                 paused,
  output logic                 pause_cpu,
  output logic [DUMPWIDTH-1:0] ram_address,
  output logic [7:0]           ram_data_in,
  output logic                 ram_write,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned Depth = 2 ** DUMPWIDTH;
  localparam int unsigned LenW  = DUMPWIDTH + 1;

  typedef logic [LenW-1:0] len_t;

  typedef enum logic [2:0] {
    StIdle, StCapture, StDelay, StPrePause, StRead, StWrite, StPostPause, StRelease
  } state_e;

  state_e state_q, state_d;
  logic   dl_q;
  len_t   len_q, len_d;
  len_t   idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  mem [Depth];
  logic [7:0]  rd_data_q;

  logic                 is_dump, dump_start, dl_fall, cap_we;
  logic [DUMPWIDTH-1:0] cap_addr;
  len_t                 cap_len, idx_inc;
  logic [31:0]          cnt_inc;
  logic                 delay_done, pad_done;

  assign is_dump    = (ioctl_index == 8'(DUMPINDEX));
  assign dump_start = ioctl_download & ~dl_q & is_dump;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign cap_we     = ioctl_download & is_dump & ioctl_wr & (ioctl_addr < 25'(Depth));
  assign cap_addr   = ioctl_addr[DUMPWIDTH-1:0];
  assign cap_len    = len_t'(cap_addr) + len_t'(1);
  assign idx_inc    = idx_q + len_t'(1);
  assign cnt_inc    = cnt_q + 32'd1;
  assign delay_done = (cnt_inc >= STARTDELAY);
  assign pad_done   = (cnt_inc >= 32'(PAUSEPAD));

  // Single-port buffer: a capture write wins, otherwise the restore index is read.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem[cap_addr] <= ioctl_dout;
    end else begin
      rd_data_q <= mem[idx_q[DUMPWIDTH-1:0]];
    end
  end

  // Length restarts at a new dump download and tracks highest captured address + 1.
  always_comb begin
    len_d = dump_start ? '0 : len_q;
    if (cap_we && (cap_len > len_d)) len_d = cap_len;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (dump_start) state_d = StCapture;
      end
      StCapture: begin
        if (dl_fall) begin
          state_d = (len_q != '0) ? StDelay : StIdle;
          cnt_d   = '0;
        end
      end
      StDelay: begin
        if (delay_done) begin
          state_d = StPrePause;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPrePause: begin
        if (paused) begin
          if (pad_done) begin
            state_d = StRead;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StRead: begin
        if (paused) state_d = StWrite;
      end
      StWrite: begin
        // Losing paused here drops back to READ without consuming the byte.
        if (paused) begin
          idx_d = idx_inc;
          if (idx_inc < len_q) begin
            state_d = StRead;
          end else begin
            state_d = StPostPause;
            cnt_d   = '0;
          end
        end else begin
          state_d = StRead;
        end
      end
      StPostPause: begin
        if (paused) begin
          if (pad_done) begin
            state_d = StRelease;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // A fresh dump download aborts any restore in progress.
    if (dump_start && (state_q != StCapture)) begin
      state_d = StCapture;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      dl_q    <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pause_cpu   = (state_q == StPrePause) || (state_q == StRead) ||
                       (state_q == StWrite) || (state_q == StPostPause);
  assign ram_write   = (state_q == StWrite) && paused && !dump_start;
  assign ram_address = idx_q[DUMPWIDTH-1:0];
  assign ram_data_in = (state_q == StWrite) ? rd_data_q : 8'h00;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StRelease);

endmodule

// File: tb/tb_nvram_restore.sv
module tb_nvram_restore;

  localparam int unsigned DumpIdx = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        paused;
  logic        pause_cpu;
  logic [7:0]  ram_address;
  logic [7:0]  ram_data_in;
  logic        ram_write;
  logic        busy;
  logic        done;

  nvram_restore #(
    .DUMPWIDTH (8),
    .DUMPINDEX (DumpIdx),
    .STARTDELAY(32'd20),
    .PAUSEPAD  (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .paused        (paused),
    .pause_cpu     (pause_cpu),
    .ram_address   (ram_address),
    .ram_data_in   (ram_data_in),
    .ram_write     (ram_write),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Core model: paused follows pause_cpu two cycles later unless forced low.
  logic p1 = 1'b0, p2 = 1'b0, force_low = 1'b0;
  always @(posedge clk) begin
    p1 <= pause_cpu;
    p2 <= p1;
  end
  assign paused = p2 & ~force_low;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];     // {address, data} of each expected RAM write
  int          exp_done = 0; // completion pulses still owed
  logic [7:0]  model_mem [256];
  int          wr_seen = 0;
  bit          pause_seen = 0;

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (pause_cpu) pause_seen = 1;
        if (ram_write) begin
          wr_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=%02h, required no write",
                     ram_address, ram_data_in);
          end else begin
            e = exp_q.pop_front();
            if ({ram_address, ram_data_in} !== e || !paused) begin
              errors++;
              $display("FAIL ram_write: addr=%0d data=%02h paused=%0b, required addr=%0d data=%02h paused=1",
                       ram_address, ram_data_in, paused, e[15:8], e[7:0]);
            end
          end
        end
        if (done) begin
          checks++;
          if (exp_done == 0) begin
            errors++;
            $display("FAIL unexpected_done: done=1, required 0");
          end else begin
            exp_done--;
          end
        end
      end
    end
  endtask

  // Streams n bytes at addresses 0..n-1 and records the expected replay.
  task automatic download(input int n, input bit strobe, input logic [7:0] idx);
    int lenm = 0;
    @(posedge clk); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      ioctl_wr   = strobe;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'($urandom);
      if (strobe && idx == 8'(DumpIdx) && i < 256) begin
        model_mem[i] = ioctl_dout;
        lenm = i + 1;
      end
      @(posedge clk); #1;
    end
    ioctl_wr = 1'b0;
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    if (idx == 8'(DumpIdx)) begin
      for (int j = 0; j < lenm; j++) exp_q.push_back({8'(j), model_mem[j]});
      if (lenm > 0) exp_done++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name, input int budget, input bit jitter);
    int k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #1;
      if (jitter) force_low = ($urandom_range(0, 5) == 0);
      k++;
    end
    force_low = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b, required 0 within %0d cycles", name, busy, budget);
    end
    checks++;
    if (exp_q.size() != 0 || exp_done != 0) begin
      errors++;
      $display("FAIL %s_complete: writes_left=%0d done_left=%0d, required 0 and 0",
               name, exp_q.size(), exp_done);
    end
  endtask

  task automatic wait_writes(input string name, input int target);
    int k = 0;
    while (wr_seen < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (wr_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: writes=%0d, required %0d", name, wr_seen, target);
    end
  endtask

  initial begin
    int base;
    int k;
    fork
      monitor();
    join_none

    #1;
    checks++;
    if ({pause_cpu, ram_write, ram_address, ram_data_in, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: pause=%0b wr=%0b addr=%0d data=%02h busy=%0b done=%0b, required all 0",
               pause_cpu, ram_write, ram_address, ram_data_in, busy, done);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Foreign index is ignored entirely.
    pause_seen = 0;
    download(10, 1'b1, 8'd2);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (busy || pause_seen) begin
      errors++;
      $display("FAIL other_index: busy=%0b pause_seen=%0b, required 0 and 0", busy, pause_seen);
    end

    // 16 bytes, fixed pattern.
    @(posedge clk); #1;
    ioctl_index = 8'(DumpIdx);
    ioctl_download = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(8'h10 + i);
      model_mem[i] = ioctl_dout;
      @(posedge clk); #1;
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    for (int j = 0; j < 16; j++) exp_q.push_back({8'(j), 8'(8'h10 + j)});
    exp_done++;
    wait_idle("basic16", 2000, 1'b0);
    checks++;
    if (pause_cpu) begin
      errors++;
      $display("FAIL basic16_release: pause_cpu=%0b, required 0", pause_cpu);
    end

    // Oversized download: only the first 256 bytes are replayed.
    download(300, 1'b1, 8'(DumpIdx));
    wait_idle("oversize", 3000, 1'b0);

    // No strobes: nothing restored, no pause.
    pause_seen = 0;
    download(20, 1'b0, 8'(DumpIdx));
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (busy || pause_seen) begin
      errors++;
      $display("FAIL empty_dump: busy=%0b pause_seen=%0b, required 0 and 0", busy, pause_seen);
    end

    // paused withheld for 50 cycles after the halt request.
    download(16, 1'b1, 8'(DumpIdx));
    k = 0;
    while (!pause_cpu && k < 500) begin @(negedge clk); k++; end
    force_low = 1'b1;
    base = wr_seen;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (wr_seen != base || !pause_cpu) begin
      errors++;
      $display("FAIL paused_hold: writes=%0d pause_cpu=%0b, required 0 writes and pause 1",
               wr_seen - base, pause_cpu);
    end
    force_low = 1'b0;
    wait_idle("paused_hold", 2000, 1'b0);

    // paused drops for 10 cycles after byte 5.
    base = wr_seen;
    download(16, 1'b1, 8'(DumpIdx));
    wait_writes("gap", base + 6);
    @(posedge clk); #1;
    force_low = 1'b1;
    repeat (10) @(posedge clk);
    #1 force_low = 1'b0;
    wait_idle("gap", 2000, 1'b0);
    checks++;
    if (wr_seen - base != 16) begin
      errors++;
      $display("FAIL gap_count: writes=%0d, required 16", wr_seen - base);
    end

    // Reset during byte 8.
    base = wr_seen;
    download(16, 1'b1, 8'(DumpIdx));
    wait_writes("reset", base + 8);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pause_cpu || ram_write || busy || done) begin
      errors++;
      $display("FAIL reset_abort: pause=%0b wr=%0b busy=%0b done=%0b, required all 0",
               pause_cpu, ram_write, busy, done);
    end
    exp_q.delete();
    exp_done = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b, required 0", busy);
    end
    download(16, 1'b1, 8'(DumpIdx));
    wait_idle("after_reset", 2000, 1'b0);

    // New download during the start delay aborts the pending restore.
    download(12, 1'b1, 8'(DumpIdx));
    repeat (5) @(posedge clk);
    #1;
    exp_q.delete();
    exp_done = 0;
    download(9, 1'b1, 8'(DumpIdx));
    wait_idle("abort", 2000, 1'b0);

    // Random lengths with a jittery paused handshake.
    for (int r = 0; r < 5; r++) begin
      download($urandom_range(1, 40), 1'b1, 8'(DumpIdx));
      wait_idle("random", 3000, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
